obstacle_collision_detector: RTL and testbench
==============================================

Name: obstacle_collision_detector

Overview:
- Produces the `collision` signal that the player height logic consumes.
- Owns one scrolling pickup obstacle. The obstacle spawns at the right screen edge in one of four vertical lanes and moves left each game tick.
- Each game tick, the block tests the obstacle against the player rectangle. The player rectangle's height is taken from the fed-back `current_height`.
- On a hit, the block consumes the obstacle and holds `collision` high for exactly one game-tick period, so a downstream sampler clocked by `game_en` sees a clean rising edge.

Parameters:
- SCREEN_W, 10'd640, obstacle spawn x coordinate.
- GROUND_Y, 10'd450, y coordinate of the player's feet (bottom of the player rectangle).
- PLAYER_X, 10'd100, left x of the player rectangle.
- PLAYER_W, 10'd30, player rectangle width.
- OBJ_W, 10'd20, obstacle width.
- OBJ_H, 10'd20, obstacle height.
- LANE_STEP, 10'd60, vertical spacing between lanes.
- SPEED, 10'd4, pixels moved left per game tick.
- MIN_GAP, 6'd16, minimum number of idle game ticks between obstacles.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  Reset, asynchronous and active-low (0 = reset).
- game_en  input  1  One-clk-wide game tick enable.
- current_height  input  10  Player total height in pixels.
- collision  output  1  High for one game-tick period per hit.
- obj_x  output  10  Obstacle left x.
- obj_y  output  10  Obstacle top y.
- obj_visible  output  1  Obstacle is live and should be drawn.

Behaviour:
- State changes happen only on clk cycles where game_en=1. With game_en=0, all registers hold.
- Reset values:
  - state=WAIT, gap counter=MIN_GAP, lfsr=LFSR_SEED.
  - collision=0, obj_x=0, obj_y=0, obj_visible=0.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances on every game_en tick in every state.
  - Never reaches all-zero.
- Player top: player_top = GROUND_Y - current_height, saturating at 0 when current_height >= GROUND_Y.
- Overlap is combinational from registered values. It is true when all of the following hold:
  - obj_x < PLAYER_X+PLAYER_W
  - obj_x+OBJ_W > PLAYER_X
  - obj_y < GROUND_Y
  - obj_y+OBJ_H > player_top
- Overlap arithmetic is 11 bits wide with no wrap; comparisons are unsigned.
- State WAIT, on each tick:
  - If gap==0: spawn. Set obj_x=SCREEN_W, lane=lfsr[1:0], obj_y=GROUND_Y-OBJ_H-lane*LANE_STEP, obj_visible=1, go to MOVE.
  - Else: gap decrements by 1.
- State MOVE, on each tick, with priorities as listed:
  - (1) If overlap: set collision=1, obj_visible=0, go to HIT. obj_x and obj_y hold.
  - (2) Else if obj_x < SPEED: set obj_visible=0, load gap=MIN_GAP+lfsr[3:0], go to WAIT. No wrap below 0.
  - (3) Else: obj_x decreases by SPEED.
- State HIT, on the next tick: set collision=0, load gap=MIN_GAP+lfsr[3:0], go to WAIT.
  - Net effect: collision rises on the tick that detects the hit and falls on the following tick. It is high for one game tick, never more than once per obstacle.
- current_height changing on the hit tick: overlap uses the value present on that tick. The height update that follows does not cause a second hit, because the obstacle is already consumed.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any active collision drops to 0.
- The unused state encoding recovers to WAIT.

Decomposition:
- Shared package (game_pkg):
  - Screen geometry constants: SCREEN_W, GROUND_Y, PLAYER_X, PLAYER_W.
  - Obstacle size and lane constants.
  - 2-bit state encoding: WAIT=0, MOVE=1, HIT=2.
- Sub-module game_lfsr8: 8-bit LFSR with ports clk, rst, en, seed parameter, and q[7:0]. It is reusable by later obstacle and scoring blocks.
- Overlap comparator and FSM live in obstacle_collision_detector.

Test Plan:
- Reset and first spawn:
  - Check: after reset, collision=0, obj_visible=0, obj_x=0.
  - Stimulus: game_en pulsed every 8 clks.
  - Required response: obj_visible rises on the 17th tick, with obj_x=640 and obj_y in {430,370,310,250}.
- Lane-0 hit:
  - Stimulus: seed chosen so that the first lane is 0 (obj_y=430); current_height=30.
  - Required response: obj_x steps 640→636→…→128 over 128 ticks. On tick 129 after spawn, collision=1 and obj_visible=0. On tick 130, collision=0 and state is WAIT.
- Miss:
  - Stimulus: lane 3 (obj_y=250); current_height=30.
  - Required response: no collision. obj_x reaches 0; on the next tick obj_visible=0 and the gap reloads to a value in 16..31.
- Tall player:
  - Stimulus: current_height=500 (saturated top=0); lane 3.
  - Required response: collision is asserted when obj_x=128, same timing as the lane-0 case.
- Enable gating and async reset:
  - Stimulus: hold game_en=0 for 100 clks during MOVE.
  - Required response: obj_x is unchanged.
  - Stimulus: assert rst=0 mid-cycle while collision=1.
  - Required response: collision=0 immediately, without waiting for a clk edge; reset values restored.
- Repeated hits: run 3 obstacles in lane 0 back to back. Exactly 3 collision pulses, each one tick wide and separated by at least 17 ticks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game geometry, obstacle constants and state encoding used by the
// obstacle, scoring and player blocks.
package game_pkg;

  localparam logic [9:0] SCREEN_W  = 10'd640;
  localparam logic [9:0] GROUND_Y  = 10'd450;
  localparam logic [9:0] PLAYER_X  = 10'd100;
  localparam logic [9:0] PLAYER_W  = 10'd30;

  localparam logic [9:0] OBJ_W     = 10'd20;
  localparam logic [9:0] OBJ_H     = 10'd20;
  localparam logic [9:0] LANE_STEP = 10'd60;
  localparam logic [9:0] SPEED     = 10'd4;
  localparam logic [5:0] MIN_GAP   = 6'd16;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    MOVE = 2'd1,
    HIT  = 2'd2
  } obj_state_t;

  // Lane 0 sits on the ground; each higher lane is LANE_STEP pixels further up.
  function automatic logic [9:0] lane_top_y(input logic [1:0] lane);
    return GROUND_Y - OBJ_H - (10'(lane) * LANE_STEP);
  endfunction

endpackage

// File: rtl/game_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping once per enable; shared by
// the obstacle and scoring blocks as a cheap pseudo-random source.
module game_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  // The all-zero lock-up state is unreachable from a nonzero seed, but is
  // still steered back to the seed so a corrupted register cannot stick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (en) begin
      if (q == 8'd0) q <= SEED;
      else           q <= {q[6:0], feedback};
    end
  end

endmodule

// File: rtl/obstacle_collision_detector.sv
// Owns one scrolling pickup obstacle, tests it against the player rectangle
// each game tick and raises a one-tick collision pulse when it is caught.
module obstacle_collision_detector
  import game_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic [9:0] current_height,
  output logic       collision,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic       obj_visible
);

  obj_state_t state_q, state_d;
  logic [6:0] gap_q, gap_d;
  logic [9:0] x_d, y_d;
  logic       vis_d, col_d;
  logic [7:0] lfsr;
  logic [6:0] gap_reload;
  logic       unused_lfsr_hi;

  logic [10:0] player_top;
  logic [10:0] player_right;
  logic [10:0] obj_right;
  logic [10:0] obj_bottom;
  logic        overlap;

  game_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (game_en),
    .q   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:4];
  assign gap_reload     = 7'(MIN_GAP) + 7'(lfsr[3:0]);

  // Eleven-bit geometry so edge sums near the screen limit cannot wrap.
  assign player_top   = (current_height >= GROUND_Y) ? 11'd0
                      : ({1'b0, GROUND_Y} - {1'b0, current_height});
  assign player_right = {1'b0, PLAYER_X} + {1'b0, PLAYER_W};
  assign obj_right    = {1'b0, obj_x} + {1'b0, OBJ_W};
  assign obj_bottom   = {1'b0, obj_y} + {1'b0, OBJ_H};

  assign overlap = ({1'b0, obj_x} < player_right) &&
                   (obj_right > {1'b0, PLAYER_X}) &&
                   (obj_y < GROUND_Y) &&
                   (obj_bottom > player_top);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT;
      gap_q       <= 7'(MIN_GAP);
      obj_x       <= 10'd0;
      obj_y       <= 10'd0;
      obj_visible <= 1'b0;
      collision   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      obj_x       <= x_d;
      obj_y       <= y_d;
      obj_visible <= vis_d;
      collision   <= col_d;
    end
  end

  // A hit takes priority over running off the left edge; the obstacle is
  // consumed on the hit tick so it can never produce a second pulse.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    x_d     = obj_x;
    y_d     = obj_y;
    vis_d   = obj_visible;
    col_d   = collision;

    if (game_en) begin
      case (state_q)
        WAIT: begin
          if (gap_q == 7'd0) begin
            x_d     = SCREEN_W;
            y_d     = lane_top_y(lfsr[1:0]);
            vis_d   = 1'b1;
            state_d = MOVE;
          end else begin
            gap_d = gap_q - 7'd1;
          end
        end
        MOVE: begin
          if (overlap) begin
            col_d   = 1'b1;
            vis_d   = 1'b0;
            state_d = HIT;
          end else if (obj_x < SPEED) begin
            vis_d   = 1'b0;
            gap_d   = gap_reload;
            state_d = WAIT;
          end else begin
            x_d = obj_x - SPEED;
          end
        end
        HIT: begin
          col_d   = 1'b0;
          gap_d   = gap_reload;
          state_d = WAIT;
        end
        default: begin
          col_d   = 1'b0;
          vis_d   = 1'b0;
          gap_d   = gap_reload;
          state_d = WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_collision_detector.sv
// Scoreboard bench for obstacle_collision_detector: a reference model queues
// the expected outputs of every game tick and a monitor checks them.
module tb_obstacle_collision_detector;

  logic       clk;
  logic       rst;
  logic       game_en;
  logic [9:0] current_height;
  logic       collision;
  logic [9:0] obj_x;
  logic [9:0] obj_y;
  logic       obj_visible;

  typedef struct {
    int x;
    int y;
    int vis;
    int col;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_state;
  int         m_gap;
  int         m_x;
  int         m_y;
  int         m_vis;
  int         m_col;
  logic [7:0] m_lfsr;

  obstacle_collision_detector #(.LFSR_SEED(8'hA5)) dut (
    .clk            (clk),
    .rst            (rst),
    .game_en        (game_en),
    .current_height (current_height),
    .collision      (collision),
    .obj_x          (obj_x),
    .obj_y          (obj_y),
    .obj_visible    (obj_visible)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_gap   = 16;
    m_x     = 0;
    m_y     = 0;
    m_vis   = 0;
    m_col   = 0;
    m_lfsr  = 8'hA5;
  endtask

  // One game tick of the behavioural model (0=WAIT, 1=MOVE, 2=HIT)
  task automatic modelStep();
    int  top;
    int  lane;
    bit  hit;
    top  = (int'(current_height) >= 450) ? 0 : 450 - int'(current_height);
    hit  = (m_x < 130) && (m_x + 20 > 100) && (m_y < 450) && (m_y + 20 > top);
    lane = int'(m_lfsr[1:0]);
    case (m_state)
      0: begin
        if (m_gap == 0) begin
          m_x = 640; m_y = 430 - lane * 60; m_vis = 1; m_state = 1;
        end else begin
          m_gap = m_gap - 1;
        end
      end
      1: begin
        if (hit) begin
          m_col = 1; m_vis = 0; m_state = 2;
        end else if (m_x < 4) begin
          m_vis = 0; m_gap = 16 + int'(m_lfsr[3:0]); m_state = 0;
        end else begin
          m_x = m_x - 4;
        end
      end
      default: begin
        m_col = 0; m_gap = 16 + int'(m_lfsr[3:0]); m_state = 0;
      end
    endcase
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  // Issue n game ticks, one every 8 clocks, queueing the expected result of each
  task automatic applyStimulus(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      modelStep();
      e.x = m_x; e.y = m_y; e.vis = m_vis; e.col = m_col;
      exp_q.push_back(e);
      game_en = 1'b1;
      @(negedge clk);
      game_en = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  // Monitor: every tick edge produces one new set of outputs to compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (game_en === 1'b1 && rst === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_obj_x", int'(obj_x), e.x);
          checkOutput("sb_obj_y", int'(obj_y), e.y);
          checkOutput("sb_visible", int'(obj_visible), e.vis);
          checkOutput("sb_collision", int'(collision), e.col);
        end
      end
    end
  end

  initial begin
    bit prev_vis;
    bit prev_col;
    bit found;
    int t;
    int w;
    int rises;
    int last_rise;
    int min_sep;
    int wide;

    rst            = 1'b0;
    game_en        = 1'b0;
    current_height = 10'd30;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("reset_collision", int'(collision), 0);
    checkOutput("reset_visible", int'(obj_visible), 0);
    checkOutput("reset_obj_x", int'(obj_x), 0);
    checkOutput("reset_obj_y", int'(obj_y), 0);
    rst = 1'b1;

    // First spawn on tick 17; seed A5 gives lane 0
    applyStimulus(16);
    checkOutput("pre_spawn_visible", int'(obj_visible), 0);
    applyStimulus(1);
    checkOutput("spawn_visible", int'(obj_visible), 1);
    checkOutput("spawn_obj_x", int'(obj_x), 640);
    checkOutput("spawn_obj_y", int'(obj_y), 430);

    // Enable gating: no ticks for 100 clocks mid-flight
    applyStimulus(50);
    checkOutput("move50_obj_x", int'(obj_x), 440);
    repeat (100) @(negedge clk);
    checkOutput("gated_obj_x", int'(obj_x), 440);
    checkOutput("gated_obj_x_model", int'(obj_x), m_x);

    // Lane-0 hit at obj_x=128 with a 30-pixel player
    applyStimulus(78);
    checkOutput("approach_obj_x", int'(obj_x), 128);
    checkOutput("approach_collision", int'(collision), 0);
    applyStimulus(1);
    checkOutput("hit_collision", int'(collision), 1);
    checkOutput("hit_visible", int'(obj_visible), 0);
    checkOutput("hit_obj_x", int'(obj_x), 128);
    applyStimulus(1);
    checkOutput("after_hit_collision", int'(collision), 0);
    checkOutput("after_hit_visible", int'(obj_visible), 0);

    // Miss: run until an obstacle leaves the screen without a hit
    prev_vis = obj_visible;
    found    = 1'b0;
    t        = 0;
    while (!found && t < 3000) begin
      applyStimulus(1);
      t++;
      if (prev_vis && !obj_visible && !collision) found = 1'b1;
      prev_vis = obj_visible;
    end
    checkOutput("miss_found", int'(found), 1);
    if (found) begin
      checkOutput("miss_obj_x", int'(obj_x), 0);
      w = 0;
      while (!obj_visible && w < 40) begin
        applyStimulus(1);
        w++;
      end
      checkRange("miss_gap_ticks", w, 17, 32);
    end

    // Tall player: every lane hits; three back-to-back one-tick pulses
    current_height = 10'd500;
    rises     = 0;
    last_rise = -1;
    min_sep   = 1000000;
    wide      = 0;
    prev_col  = collision;
    t         = 0;
    while (rises < 3 && t < 3000) begin
      applyStimulus(1);
      t++;
      if (collision && !prev_col) begin
        rises++;
        checkOutput("tall_hit_obj_x", int'(obj_x), 128);
        if (last_rise >= 0 && (t - last_rise) < min_sep) min_sep = t - last_rise;
        last_rise = t;
      end
      if (collision && prev_col) wide++;
      prev_col = collision;
    end
    checkOutput("tall_pulse_count", rises, 3);
    checkOutput("pulse_width_violations", wide, 0);
    checkRange("pulse_separation", min_sep, 17, 1000000);

    // Asynchronous reset between clock edges while collision is high
    checkOutput("pre_reset_collision", int'(collision), 1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_collision", int'(collision), 0);
    checkOutput("async_visible", int'(obj_visible), 0);
    checkOutput("async_obj_x", int'(obj_x), 0);
    checkOutput("async_obj_y", int'(obj_y), 0);
    modelReset();
    current_height = 10'd30;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    applyStimulus(16);
    checkOutput("rerun_pre_spawn_visible", int'(obj_visible), 0);
    applyStimulus(1);
    checkOutput("rerun_spawn_obj_x", int'(obj_x), 640);
    checkOutput("rerun_spawn_obj_y", int'(obj_y), 430);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
